// File: rtl/pico_mem_pkg.sv
// Shared types, status bit positions and default register map for pico_mem_ctrl.

package pico_mem_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  typedef enum logic [1:0] {
    SelRam,
    SelCon,
    SelStat,
    SelBad
  } sel_e;

  localparam int unsigned StatusEmptyBit = 0;
  localparam int unsigned StatusFullBit  = 1;
  localparam int unsigned StatusFaultBit = 2;
  localparam int unsigned StatusCountLsb = 8;

  localparam logic [31:0] DefaultAddrBase    = 32'h0000_0000;
  localparam logic [31:0] DefaultConsoleAddr = 32'h1000_0000;
  localparam logic [31:0] DefaultStatusAddr  = 32'h1000_0004;

  // Registers win over RAM so the map stays sane if ADDR_BASE overlaps them.
  function automatic sel_e decode_addr(input logic [31:0] addr,
                                       input logic [31:0] offset,
                                       input logic        write,
                                       input logic [31:0] con_addr,
                                       input logic [31:0] stat_addr,
                                       input logic [32:0] ram_bytes);
    if (addr[31:2] == con_addr[31:2]) return SelCon;
    if (addr[31:2] == stat_addr[31:2]) return write ? SelBad : SelStat;
    if ({1'b0, offset} < ram_bytes) return SelRam;
    return SelBad;
  endfunction

endpackage

// File: rtl/pico_console_fifo.sv
// Synchronous FIFO for console bytes; head and valid are registered outputs.

module pico_console_fifo #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [Width-1:0]       push_data,
  input  logic                   pop,
  output logic [Width-1:0]       head,
  output logic                   valid,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(Depth):0] count
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_q, rd_q, rd_d;
  logic [PtrW:0]    cnt_q, cnt_d, cnt_after_pop;
  logic [Width-1:0] head_q, head_d;
  logic             valid_q;
  logic             do_push, do_pop;

  assign full    = (cnt_q == (PtrW + 1)'(Depth));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    rd_d          = rd_q + PtrW'(do_pop);
    cnt_after_pop = cnt_q - (PtrW + 1)'(do_pop);
    cnt_d         = cnt_after_pop + (PtrW + 1)'(do_push);
    // A push into an otherwise-empty FIFO becomes the head directly.
    if (cnt_d == '0) begin
      head_d = '0;
    end else if (cnt_after_pop == '0) begin
      head_d = push_data;
    end else begin
      head_d = mem_q[rd_d];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      head_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      if (do_push) wr_q <= wr_q + PtrW'(1);
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      valid_q <= (cnt_d != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_data;
  end

  assign head  = head_q;
  assign valid = valid_q;
  assign count = cnt_q;

endmodule

// File: rtl/pico_mem_ctrl.sv
// picorv32 native-bus RAM + console slave with wait states and sticky fault.
// Define PICO_MEM_CONSOLE_EN to build the console FIFO, stream port and full status register.

module pico_mem_ctrl import pico_mem_pkg::*; #(
  parameter int unsigned MEM_WORDS    = 65536,
  parameter logic [31:0] ADDR_BASE    = DefaultAddrBase,
  parameter int unsigned WAIT_STATES  = 1,
  parameter logic [31:0] CONSOLE_ADDR = DefaultConsoleAddr,
  parameter logic [31:0] STATUS_ADDR  = DefaultStatusAddr,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter string       INIT_FILE    = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        con_valid,
  output logic [7:0]  con_data,
  input  logic        con_ready,
  output logic        fault
);

  localparam int unsigned IdxW     = $clog2(MEM_WORDS);
  localparam logic [32:0] RamBytes = 33'(MEM_WORDS) * 33'd4;

  state_e          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  sel_e            sel_q;
  logic [IdxW-1:0] idx_q;
  logic [31:0]     wdata_q;
  logic [3:0]      wstrb_q;
  logic [31:0]     rdata_q;
  logic            fault_q;
  logic            enter_resp;
  logic            con_stall;
  logic [31:0]     status;
  logic [31:0]     offset;

  logic [31:0] mem [MEM_WORDS];

  assign offset = mem_addr - ADDR_BASE;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mem_valid) begin
          state_d = StWait;
          cnt_d   = 3'(WAIT_STATES);
        end
      end
      StWait: begin
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else if (!con_stall) begin
          state_d    = StResp;
          enter_resp = 1'b1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sel_q   <= SelRam;
      idx_q   <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == StIdle && mem_valid) begin
        sel_q   <= decode_addr(mem_addr, offset, mem_wstrb != 4'h0, CONSOLE_ADDR, STATUS_ADDR,
                               RamBytes);
        idx_q   <= offset[IdxW+1:2];
        wdata_q <= mem_wdata;
        wstrb_q <= mem_wstrb;
      end
      if (enter_resp && sel_q == SelBad) fault_q <= 1'b1;
    end
  end

  // RAM port and response capture; writes land in RESP, reads are sampled on entry to RESP.
  always_ff @(posedge clk) begin
    if (state_q == StResp && sel_q == SelRam) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
    if (enter_resp) begin
      if (wstrb_q != 4'h0) begin
        rdata_q <= '0;
      end else begin
        unique case (sel_q)
          SelRam:  rdata_q <= mem[idx_q];
          SelStat: rdata_q <= status;
          default: rdata_q <= '0;
        endcase
      end
    end
  end

`ifdef PICO_MEM_CONSOLE_EN
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  logic [CntW-1:0] fifo_count;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_push;

  assign fifo_push = enter_resp && sel_q == SelCon && wstrb_q[0];
  assign con_stall = fifo_full && sel_q == SelCon && wstrb_q != 4'h0;

  pico_console_fifo #(
    .Depth(FIFO_DEPTH),
    .Width(8)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifo_push),
    .push_data(wdata_q[7:0]),
    .pop      (con_valid && con_ready),
    .head     (con_data),
    .valid    (con_valid),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_comb begin
    status                          = '0;
    status[StatusEmptyBit]          = fifo_empty;
    status[StatusFullBit]           = fifo_full;
    status[StatusFaultBit]          = fault_q;
    status[StatusCountLsb +: 8]     = 8'(fifo_count);
  end
`else
  logic unused_con_ready;

  assign unused_con_ready = con_ready;
  assign con_valid        = 1'b0;
  assign con_data         = 8'h00;
  assign con_stall        = 1'b0;

  always_comb begin
    status                 = '0;
    status[StatusEmptyBit] = 1'b1;
    status[StatusFaultBit] = fault_q;
  end
`endif

  assign mem_ready = (state_q == StResp);
  assign mem_rdata = mem_ready ? rdata_q : 32'h0;
  assign fault     = fault_q;

  // Instruction fetches are reads on picorv32.
  a_fetch_is_read: assert property (@(posedge clk) disable iff (reset)
    (mem_valid && mem_instr) |-> (mem_wstrb == 4'h0));

endmodule

// File: tb/tb_pico_mem_ctrl.sv
// Directed bench for pico_mem_ctrl (WAIT_STATES=2, FIFO_DEPTH=8); console checks follow the build.

module tb_pico_mem_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid, mem_instr;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        con_valid;
  logic [7:0]  con_data;
  logic        con_ready;
  logic        fault;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] ConAddr  = 32'h1000_0000;
  localparam logic [31:0] StatAddr = 32'h1000_0004;

  pico_mem_ctrl #(
    .MEM_WORDS   (65536),
    .ADDR_BASE   (32'h0),
    .WAIT_STATES (2),
    .CONSOLE_ADDR(ConAddr),
    .STATUS_ADDR (StatAddr),
    .FIFO_DEPTH  (8),
    .INIT_FILE   ("")
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .mem_valid(mem_valid),
    .mem_instr(mem_instr),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .con_valid(con_valid),
    .con_data (con_data),
    .con_ready(con_ready),
    .fault    (fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Starts #1 after a rising edge; lat counts edges until mem_ready is seen.
  task automatic access(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        output logic [31:0] rd, output int lat);
    mem_valid = 1'b1;
    mem_addr  = a;
    mem_wdata = d;
    mem_wstrb = s;
    lat = 0;
    rd  = '0;
    while (lat < 60) begin
      @(posedge clk); #1;
      lat++;
      if (mem_ready) begin
        rd = mem_rdata;
        break;
      end
    end
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    @(posedge clk); #1;
    check("single_pulse", {31'b0, mem_ready}, 32'h0);
  endtask

  logic [31:0] rd;
  int          lat;
  logic [7:0]  rx[16];
  int          nrx;
  int          ready_at;
  logic        early;
  logic [7:0]  exp_ch;

  initial begin
    reset = 1'b1; mem_valid = 1'b0; mem_instr = 1'b0; mem_addr = '0;
    mem_wdata = '0; mem_wstrb = '0; con_ready = 1'b0;

    vecs[0]  = '{32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0};
    vecs[1]  = '{32'h0000_0100, 32'h0,         4'h0, 1'b1, 32'hDEAD_BEEF};
    vecs[2]  = '{32'h0000_0100, 32'h0000_5A00, 4'h2, 1'b0, 32'h0};
    vecs[3]  = '{32'h0000_0100, 32'h0,         4'h0, 1'b1, 32'hDEAD_5AEF};
    vecs[4]  = '{32'h0000_0104, 32'h1234_5678, 4'hF, 1'b0, 32'h0};
    vecs[5]  = '{32'h0000_0104, 32'hAABB_CCDD, 4'h9, 1'b0, 32'h0};
    vecs[6]  = '{32'h0000_0104, 32'h0,         4'h0, 1'b1, 32'hAA34_56DD};
    vecs[7]  = '{32'h0000_0103, 32'h0,         4'h0, 1'b1, 32'hDEAD_5AEF};
    vecs[8]  = '{32'h0003_FFFC, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0};
    vecs[9]  = '{32'h0003_FFFC, 32'h0,         4'h0, 1'b1, 32'hCAFE_F00D};
    vecs[10] = '{StatAddr,      32'h0,         4'h0, 1'b1, 32'h0000_0001};
    vecs[11] = '{ConAddr,       32'h0,         4'h0, 1'b1, 32'h0};

    repeat (3) @(posedge clk);
    #1;
    check("reset_mem_ready", {31'b0, mem_ready}, 32'h0);
    check("reset_mem_rdata", mem_rdata, 32'h0);
    check("reset_con_valid", {31'b0, con_valid}, 32'h0);
    check("reset_con_data", {24'b0, con_data}, 32'h0);
    check("reset_fault", {31'b0, fault}, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      access(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, rd, lat);
      check($sformatf("vec%0d_latency", i), lat, 32'd4);
      if (vecs[i].chk_rd) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
    end
    check("fault_after_table", {31'b0, fault}, 32'h0);

`ifdef PICO_MEM_CONSOLE_EN
    con_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      access(ConAddr, 32'h0000_0041 + i, 4'h1, rd, lat);
      check($sformatf("con_wr%0d_latency", i), lat, 32'd4);
    end
    check("con_valid_queued", {31'b0, con_valid}, 32'h1);
    check("con_head_A", {24'b0, con_data}, 32'h41);
    access(StatAddr, 32'h0, 4'h0, rd, lat);
    check("status_full", rd, 32'h0000_0802);

    mem_valid = 1'b1; mem_addr = ConAddr; mem_wdata = 32'h49; mem_wstrb = 4'h1;
    early = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (mem_ready) early = 1'b1;
    end
    check("ninth_write_stalls", {31'b0, early}, 32'h0);
    con_ready = 1'b1;
    nrx = 0;
    ready_at = -1;
    for (int c = 0; c < 30; c++) begin
      if (con_valid && nrx < 16) begin
        rx[nrx] = con_data;
        nrx++;
      end
      @(posedge clk); #1;
      if (mem_ready && ready_at < 0) begin
        ready_at = c + 1;
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
      end
    end
    mem_valid = 1'b0;
    con_ready = 1'b0;
    check("ninth_ready_after_pop", ready_at, 32'd2);
    check("drain_count", nrx, 32'd9);
    for (int i = 0; i < 9; i++) begin
      exp_ch = 8'h41 + 8'(i);
      check($sformatf("drain_byte%0d", i), {24'b0, rx[i]}, {24'b0, exp_ch});
    end
    check("con_valid_drained", {31'b0, con_valid}, 32'h0);
`else
    access(ConAddr, 32'h0000_0041, 4'h1, rd, lat);
    check("con_wr_latency", lat, 32'd4);
    check("con_valid_tied", {31'b0, con_valid}, 32'h0);
    access(StatAddr, 32'h0, 4'h0, rd, lat);
    check("status_noconsole", rd, 32'h0000_0001);
`endif

    access(32'h2000_0000, 32'h0, 4'h0, rd, lat);
    check("bad_rd_latency", lat, 32'd4);
    check("bad_rd_rdata", rd, 32'h0);
    check("bad_fault_set", {31'b0, fault}, 32'h1);
    access(32'h0000_0100, 32'h0, 4'h0, rd, lat);
    check("ram_after_fault", rd, 32'hDEAD_5AEF);
    check("fault_sticky", {31'b0, fault}, 32'h1);
    access(32'h0004_0000, 32'h0, 4'h0, rd, lat);
    check("ram_end_plus1", rd, 32'h0);
    access(StatAddr, 32'hFFFF_FFFF, 4'hF, rd, lat);
    check("stat_wr_latency", lat, 32'd4);
    access(StatAddr, 32'h0, 4'h0, rd, lat);
    check("status_fault", rd, 32'h0000_0005);

    for (int i = 0; i < 3; i++) access(ConAddr, 32'h78 + i, 4'h1, rd, lat);
`ifdef PICO_MEM_CONSOLE_EN
    check("three_queued", {31'b0, con_valid}, 32'h1);
`endif
    mem_valid = 1'b1; mem_addr = 32'h0000_0100; mem_wdata = 32'h0; mem_wstrb = 4'hF;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("rst_mem_ready", {31'b0, mem_ready}, 32'h0);
    check("rst_con_valid", {31'b0, con_valid}, 32'h0);
    check("rst_fault", {31'b0, fault}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    @(posedge clk); #1;
    access(32'h0000_0100, 32'h0, 4'h0, rd, lat);
    check("ram_kept_after_reset", rd, 32'hDEAD_5AEF);
    check("rst_read_latency", lat, 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
